// File: rtl/buffer_reader.sv
// Sweeps a full sample buffer once per start edge and reports the peak
// magnitude, its first index and the sum of magnitudes over the run.
module buffer_reader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_calc,
  input  logic [DATA_W-1:0]          data_out,
  output logic [ADDR_W-1:0]          read_offset,
  output logic                       finished_calc,
  output logic                       result_valid,
  output logic [DATA_W-2:0]          peak_mag,
  output logic [ADDR_W-1:0]          peak_index,
  output logic [DATA_W+ADDR_W-2:0]   energy
);

  localparam int MW = DATA_W - 1;
  localparam int EW = DATA_W - 1 + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              start_q;
  logic              start_qq;
  logic              armed;
  logic              proc_en;
  logic [ADDR_W-1:0] proc_idx;
  logic [MW-1:0]     work_peak;
  logic [ADDR_W-1:0] work_idx;
  logic [EW-1:0]     work_energy;

  logic [DATA_W-1:0] neg;
  logic [MW-1:0]     mag;
  logic [MW-1:0]     nxt_peak;
  logic [ADDR_W-1:0] nxt_idx;
  logic [EW-1:0]     nxt_energy;

  // The most negative sample has no positive twin, so clamp it.
  always_comb begin
    neg = '0 - data_out;
    mag = data_out[MW-1:0];
    if (data_out[DATA_W-1]) begin
      if (data_out[MW-1:0] == '0) mag = '1;
      else                        mag = neg[MW-1:0];
    end
    nxt_peak   = work_peak;
    nxt_idx    = work_idx;
    nxt_energy = work_energy;
    if (proc_en) begin
      nxt_energy = work_energy + EW'(mag);
      if (mag > work_peak) begin
        nxt_peak = mag;
        nxt_idx  = proc_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      start_qq      <= 1'b0;
      armed         <= 1'b1;
      proc_en       <= 1'b0;
      proc_idx      <= '0;
      work_peak     <= '0;
      work_idx      <= '0;
      work_energy   <= '0;
      read_offset   <= '0;
      finished_calc <= 1'b0;
      result_valid  <= 1'b0;
      peak_mag      <= '0;
      peak_index    <= '0;
      energy        <= '0;
    end else begin
      start_q       <= start_calc;
      start_qq      <= start_q;
      proc_en       <= (state == READ);
      proc_idx      <= read_offset;
      finished_calc <= 1'b0;
      work_peak     <= nxt_peak;
      work_idx      <= nxt_idx;
      work_energy   <= nxt_energy;
      unique case (state)
        IDLE: begin
          if (start_q && !start_qq && armed) begin
            state       <= READ;
            armed       <= 1'b0;
            read_offset <= '0;
            work_peak   <= '0;
            work_idx    <= '0;
            work_energy <= '0;
          end else if (!start_q) begin
            armed <= 1'b1;
          end
        end
        READ: begin
          if (read_offset == LAST) begin
            state       <= DRAIN;
            read_offset <= '0;
          end else begin
            read_offset <= read_offset + ADDR_W'(1);
          end
        end
        // Last sample lands this cycle, so publish the next-values.
        DRAIN: begin
          state         <= DONE;
          peak_mag      <= nxt_peak;
          peak_index    <= nxt_idx;
          energy        <= nxt_energy;
          result_valid  <= 1'b1;
          finished_calc <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Randomized and directed bench for buffer_reader against a run-level
// reference model of the sweep timing and result arithmetic.
module tb_buffer_reader;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 18;
  localparam int EW     = DATA_W - 1 + ADDR_W;
  localparam int MINV   = -(1 << (DATA_W - 1));

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_calc = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] read_offset;
  logic              finished_calc;
  logic              result_valid;
  logic [DATA_W-2:0] peak_mag;
  logic [ADDR_W-1:0] peak_index;
  logic [EW-1:0]     energy;

  int mem[DEPTH];
  int total = 0;
  int passed = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;

  int m_t = -1;
  bit m_armed = 1'b1;
  bit s1 = 1'b0;
  bit s2 = 1'b0;
  int e_off = 0;
  bit e_fin = 1'b0;
  bit e_valid = 1'b0;
  int e_peak = 0;
  int e_idx = 0;
  int e_energy = 0;

  buffer_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock),
    .reset(reset),
    .start_calc(start_calc),
    .data_out(data_out),
    .read_offset(read_offset),
    .finished_calc(finished_calc),
    .result_valid(result_valid),
    .peak_mag(peak_mag),
    .peak_index(peak_index),
    .energy(energy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) data_out <= DATA_W'(mem[read_offset]);

  always @(posedge clock) begin
    cyc++;
    #1;
    if (finished_calc === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  function automatic int mag_of(input int v);
    if (v == MINV) return -MINV - 1;
    return (v < 0) ? -v : v;
  endfunction

  // Run-level model: cycle count since the start edge drives everything.
  always @(posedge clock) begin
    if (reset) begin
      m_t = -1; m_armed = 1'b1; s1 = 1'b0; s2 = 1'b0;
      e_off = 0; e_fin = 1'b0; e_valid = 1'b0;
      e_peak = 0; e_idx = 0; e_energy = 0;
    end else begin
      e_fin = 1'b0;
      if (m_t < 0) begin
        if (s1 && !s2 && m_armed) begin
          m_t = 0;
          m_armed = 1'b0;
        end else if (!s1) begin
          m_armed = 1'b1;
        end
      end else begin
        m_t++;
      end
      if (m_t == DEPTH + 1) begin
        e_fin = 1'b1;
        e_valid = 1'b1;
        e_peak = 0; e_idx = 0; e_energy = 0;
        for (int i = 0; i < DEPTH; i++) begin
          e_energy += mag_of(mem[i]);
          if (mag_of(mem[i]) > e_peak) begin
            e_peak = mag_of(mem[i]);
            e_idx = i;
          end
        end
      end
      if (m_t == DEPTH + 2) m_t = -1;
      e_off = (m_t >= 0 && m_t < DEPTH) ? m_t : 0;
      s2 = s1;
      s1 = start_calc;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      total++;
      if (read_offset !== ADDR_W'(e_off) || finished_calc !== e_fin ||
          result_valid !== e_valid || peak_mag !== (DATA_W-1)'(e_peak) ||
          peak_index !== ADDR_W'(e_idx) || energy !== EW'(e_energy)) begin
        $display("FAIL cycle%0d off=%0d/%0d fin=%0b/%0b vld=%0b/%0b pk=%0d/%0d idx=%0d/%0d en=%0d/%0d",
                 cyc, read_offset, e_off, finished_calc, e_fin, result_valid, e_valid,
                 peak_mag, e_peak, peak_index, e_idx, energy, e_energy);
      end else begin
        passed++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  task automatic do_run(input string nm, input int hold);
    int f0;
    int e0;
    f0 = fin_cnt;
    start_calc = 1'b1;
    e0 = cyc + 1;
    repeat (hold) @(negedge clock);
    start_calc = 1'b0;
    for (int c = 0; c < DEPTH + 20 && fin_cnt == f0; c++) @(negedge clock);
    chk({nm, "_pulses"}, fin_cnt - f0, 1);
    chk({nm, "_latency"}, fin_cyc - e0, DEPTH + 2);
    repeat (3) @(negedge clock);
    chk({nm, "_pulses_after"}, fin_cnt - f0, 1);
  endtask

  task automatic wait_off(input int target, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < 2 * DEPTH && !hit; c++) begin
      @(negedge clock);
      if (read_offset == ADDR_W'(target)) hit = 1'b1;
    end
  endtask

  initial begin
    bit hit;
    int f0;
    int p1;
    int i1;
    int en1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 0;

    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    repeat (6) begin
      @(negedge clock);
      start_calc = ~start_calc;
    end
    @(negedge clock);
    start_calc = 1'b0;
    chk("reset_offset", read_offset, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_energy", energy, 0);
    chk("reset_fin", fin_cnt, 0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    chk("no_run_after_reset", fin_cnt + read_offset, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = 100 + 10 * i;
    do_run("ramp", 3);
    chk("ramp_peak", peak_mag, 5210);
    chk("ramp_index", peak_index, 511);
    chk("ramp_energy", energy, 1359360);
    chk("ramp_valid", result_valid, 1);

    for (int i = 0; i < DEPTH; i++) mem[i] = 0;
    mem[7] = MINV;
    do_run("sat", 1);
    chk("sat_peak", peak_mag, 131071);
    chk("sat_index", peak_index, 7);
    chk("sat_energy", energy, 131071);

    mem[7] = 0;
    mem[3] = -500;
    mem[200] = 500;
    do_run("tie", 2);
    chk("tie_peak", peak_mag, 500);
    chk("tie_index", peak_index, 3);
    chk("tie_energy", energy, 1000);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = int'($urandom_range(262143)) - 131072;
        if ($urandom_range(15) == 0) mem[i] = MINV;
      end
      do_run("rand", 1 + int'($urandom_range(4)));
    end

    f0 = fin_cnt;
    start_calc = 1'b1;
    wait_off(100, hit);
    chk("abort_reach_100", hit, 1);
    reset = 1'b1;
    start_calc = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (DEPTH + 10) @(negedge clock);
    chk("abort_no_fin", fin_cnt - f0, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_peak", peak_mag, 0);
    chk("abort_energy", energy, 0);
    do_run("after_abort", 2);

    f0 = fin_cnt;
    start_calc = 1'b1;
    repeat (DEPTH + 40) @(negedge clock);
    chk("hold_one_run", fin_cnt - f0, 1);
    p1 = peak_mag;
    i1 = peak_index;
    en1 = energy;
    for (int i = 0; i < DEPTH; i++) mem[i] = int'($urandom_range(2000)) - 1000;
    start_calc = 1'b0;
    @(negedge clock);
    start_calc = 1'b1;
    wait_off(200, hit);
    chk("rearm_started", hit, 1);
    chk("rearm_hold_peak", peak_mag, p1);
    chk("rearm_hold_index", peak_index, i1);
    chk("rearm_hold_energy", energy, en1);
    for (int c = 0; c < DEPTH + 20 && fin_cnt == f0 + 1; c++) @(negedge clock);
    chk("rearm_second_run", fin_cnt - f0, 2);
    start_calc = 1'b0;
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameter DEPTH, default 512, number of buffer samples swept per run.
REQ-002 Parameter ADDR_W, default 9, width of read_offset (log2 DEPTH).
REQ-003 Parameter DATA_W, default 18, signed sample width.
REQ-004 clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_calc  input  1  buffer-full indication from the sample buffer; a run starts on its rising edge.
REQ-007 data_out  input  DATA_W  signed two's-complement sample from the buffer; valid one cycle after read_offset is presented.
REQ-008 read_offset  output  ADDR_W  sample index requested from the buffer.
REQ-009 finished_calc  output  1  one-cycle pulse to the buffer when a run completes.
REQ-010 result_valid  output  1  high once results from a completed run are held.
REQ-011 peak_mag  output  DATA_W-1  largest sample magnitude seen in the last completed run.
REQ-012 peak_index  output  ADDR_W  offset of the first sample that reached peak_mag.
REQ-013 energy  output  DATA_W-1+ADDR_W  sum of sample magnitudes over the last completed run.

Function
REQ-014 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-015 IDLE->READ SHALL occur only when start_calc is sampled high, start_calc was low on the previous edge, and the block is armed.
REQ-016 The block SHALL be armed after reset and SHALL be disarmed on entering READ; it re-arms only when start_calc is sampled low in IDLE.
REQ-017 In READ, read_offset SHALL be 0 on the first cycle and increment by 1 each cycle up to DEPTH-1; after DEPTH-1 the FSM SHALL go to DRAIN.
REQ-018 In IDLE, DRAIN and DONE, read_offset SHALL be 0.
REQ-019 The datapath SHALL process data_out on the cycle after each offset is presented, so the sample for DEPTH-1 is processed in DRAIN; exactly DEPTH samples are processed per run.
REQ-020 Magnitude SHALL be |data_out|; the most negative value (-2^(DATA_W-1)) SHALL saturate to 2^(DATA_W-1)-1.
REQ-021 Working peak SHALL update only when magnitude > current peak (strict), so ties keep the earliest index.
REQ-022 The working energy accumulator SHALL be DATA_W-1+ADDR_W bits and cannot overflow for DEPTH samples.
REQ-023 The working peak, index and energy SHALL clear to 0 on the IDLE->READ transition.
REQ-024 DRAIN->DONE SHALL be unconditional; on entering DONE the working values SHALL be copied to peak_mag, peak_index and energy, and result_valid set to 1.
REQ-025 finished_calc SHALL be high for exactly the one DONE cycle; DONE->IDLE SHALL be unconditional.
REQ-026 Latency: if start_calc is first sampled high at edge E0, read_offset=0 after E1, DONE/finished_calc after E(DEPTH+2), and IDLE after E(DEPTH+3).
REQ-027 Result outputs SHALL hold their values until the next DONE; a run in progress SHALL NOT alter them.
REQ-028 start_calc changes during READ, DRAIN or DONE SHALL be ignored apart from the arming rule in REQ-016.

Reset
REQ-029 Reset SHALL force IDLE, arm the block, and drive read_offset, finished_calc, result_valid, peak_mag, peak_index, energy and all working registers to 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no finished_calc pulse and no result update.
REQ-031 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-032 Reset: hold reset for 10 cycles -> all outputs 0 and FSM in IDLE; toggling start_calc while reset is high starts no run.
REQ-033 Ramp: model buffer (1-cycle latency) returns 100+10*addr, then raise start_calc -> read_offset sweeps 0..511; finished_calc is a single pulse 514 edges after start; peak_mag=5210, peak_index=511, energy=1359360, result_valid=1.
REQ-034 Saturation: sample at index 7 is -131072 and all others are 0 -> peak_mag=131071, peak_index=7, energy=131071.
REQ-035 Tie: value -500 at index 3 and +500 at index 200, all others 0 -> peak_index=3, peak_mag=500, energy=1000.
REQ-036 Abort: assert reset when read_offset=100 -> no finished_calc, outputs 0; a new start_calc edge then completes a full 514-cycle run.
REQ-037 Re-arm: hold start_calc high through and past DONE -> exactly one run; drive it low for one cycle then high -> a second run starts, and results stay at the first run's values until the second DONE.
